// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, fixed N+2 cycle latency.
// Signed operands are divided as magnitudes and the signs are reapplied in the FIX cycle.
module seq_divider #(
  parameter int N = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow,
  output logic         car
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dsr_q, dsr_d;
  logic [N-1:0]  a_orig_q, a_orig_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          bzero_q, bzero_d;
  logic          ovf_case_q, ovf_case_d;
  logic          done_q, done_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  remo_q, remo_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [N-1:0]  a_mag, b_mag;
  logic [N:0]    shifted, trial;

  assign a_mag = (is_signed && A[N-1]) ? -A : A;
  assign b_mag = (is_signed && B[N-1]) ? -B : B;

  // The partial remainder always stays below the divisor, so N bits hold it;
  // only the shifted/trial value needs the extra bit to expose the borrow.
  assign shifted = {rem_q, dvd_q[N-1]};
  assign trial   = shifted - {1'b0, dsr_q};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    a_orig_d   = a_orig_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    bzero_d    = bzero_q;
    ovf_case_d = ovf_case_q;
    done_d     = 1'b0;
    quo_d      = quo_q;
    remo_d     = remo_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CALC;
          count_d    = CW'(N);
          rem_d      = '0;
          dvd_d      = a_mag;
          dsr_d      = b_mag;
          a_orig_d   = A;
          neg_quo_d  = is_signed & (A[N-1] ^ B[N-1]);
          neg_rem_d  = is_signed & A[N-1];
          bzero_d    = (B == '0);
          ovf_case_d = is_signed && (A == MIN_NEG) && (B == '1);
        end
      end
      CALC: begin
        if (!trial[N]) begin
          rem_d = trial[N-1:0];
          dvd_d = {dvd_q[N-2:0], 1'b1};
        end else begin
          rem_d = shifted[N-1:0];
          dvd_d = {dvd_q[N-2:0], 1'b0};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (bzero_q) begin
          quo_d  = '1;
          remo_d = a_orig_q;
          dbz_d  = 1'b1;
          ovf_d  = 1'b0;
        end else if (ovf_case_q) begin
          quo_d  = MIN_NEG;
          remo_d = '0;
          dbz_d  = 1'b0;
          ovf_d  = 1'b1;
        end else begin
          quo_d  = neg_quo_q ? -dvd_q : dvd_q;
          remo_d = neg_rem_q ? -rem_q : rem_q;
          dbz_d  = 1'b0;
          ovf_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      a_orig_q   <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      bzero_q    <= 1'b0;
      ovf_case_q <= 1'b0;
      done_q     <= 1'b0;
      quo_q      <= '0;
      remo_q     <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      a_orig_q   <= a_orig_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      bzero_q    <= bzero_d;
      ovf_case_q <= ovf_case_d;
      done_q     <= done_d;
      quo_q      <= quo_d;
      remo_q     <= remo_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign car         = 1'b0;

endmodule
